// File: rtl/ex_fifo_pkg.sv
// Shared defaults and types for the FIFO write arbiter.
package ex_fifo_pkg;
  localparam int EX_DATA_W_DEF  = 8;
  localparam int EX_MAX_PKT_DEF = 1024;
  localparam int EX_CNT_W       = 11;

  typedef enum logic {IDLE, XFER} state_e;
endpackage

// File: rtl/ex_fifo_rr_arb2.sv
// Two-way round-robin pick: the pointer names the requester that wins a tie.
module ex_fifo_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] win_o
);
  always_comb begin
    win_o = 2'b00;
    if (ptr_i) begin
      if (req_i[1])      win_o = 2'b10;
      else if (req_i[0]) win_o = 2'b01;
    end else begin
      if (req_i[0])      win_o = 2'b01;
      else if (req_i[1]) win_o = 2'b10;
    end
  end
endmodule

// File: rtl/ex_fifo_wr_arbiter.sv
// Packet-granular arbiter muxing two requesters onto one shared FIFO write port.
module ex_fifo_wr_arbiter
  import ex_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = EX_DATA_W_DEF,
  parameter int MAX_PKT_LEN = EX_MAX_PKT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_last,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_last,
  output logic                  req1_ready,
  input  logic                  fifo_wr_vld,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic [1:0]            grant,
  output logic                  pkt_done,
  output logic                  err_len
);
  localparam logic [EX_CNT_W-1:0] LAST_IDX = EX_CNT_W'(MAX_PKT_LEN - 1);

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 ptr_q, ptr_d;
  logic [EX_CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]           rst_sync_q;
  logic [1:0]           req_vld, win, ready;
  logic                 rst_ok, beat, beat_last, at_max;

  // Assertion is immediate; release waits two edges before arbitration may start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_ok = rst_sync_q[1];

  assign req_vld = {req1_valid, req0_valid};

  ex_fifo_rr_arb2 u_rr (
    .req_i (req_vld),
    .ptr_i (ptr_q),
    .win_o (win)
  );

  assign ready     = (state_q == XFER) ? (grant_q & {2{fifo_wr_vld}}) : 2'b00;
  assign beat      = |(ready & req_vld);
  assign beat_last = grant_q[1] ? req1_last : req0_last;
  assign at_max    = (cnt_q == LAST_IDX);

  assign req0_ready   = ready[0];
  assign req1_ready   = ready[1];
  assign fifo_wr_en   = beat;
  assign fifo_wr_data = beat ? (grant_q[1] ? req1_data : req0_data) : '0;
  assign grant        = grant_q;
  assign pkt_done     = beat & (beat_last | at_max);
  assign err_len      = beat & ~beat_last & at_max;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rst_ok && |req_vld) begin
          state_d = XFER;
          grant_d = win;
          cnt_d   = '0;
        end
      end
      XFER: begin
        if (beat) cnt_d = cnt_q + EX_CNT_W'(1);
        // Truncated packets end here too; the remainder re-arbitrates as a new packet.
        if (pkt_done) begin
          state_d = IDLE;
          grant_d = 2'b00;
          ptr_d   = grant_q[0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ex_fifo_wr_arbiter.sv
// Directed cycle-by-cycle bench; DUT built with MAX_PKT_LEN=4 so truncation is reachable.
module tb_ex_fifo_wr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data, fifo_wr_data;
  logic       fifo_wr_vld, fifo_wr_en, pkt_done, err_len;
  logic [1:0] grant;

  int n_chk  = 0;
  int n_pass = 0;
  int n_wr   = 0;
  int n_done = 0;
  int n_err  = 0;

  always #5 clk = ~clk;

  ex_fifo_wr_arbiter #(.DATA_WIDTH(8), .MAX_PKT_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .fifo_wr_vld(fifo_wr_vld), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant(grant), .pkt_done(pkt_done), .err_len(err_len)
  );

  always @(posedge clk) begin
    if (fifo_wr_en) n_wr++;
    if (pkt_done)   n_done++;
    if (err_len)    n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // One cycle: drive inputs on the falling edge, then check outputs before the next rise.
  task automatic cyc(input string tag, input logic rn,
                     input logic v0, input logic [7:0] d0, input logic l0,
                     input logic v1, input logic [7:0] d1, input logic l1, input logic wv,
                     input logic [1:0] g, input logic en, input logic [7:0] wd,
                     input logic done, input logic err);
    logic [1:0] rdy;
    @(negedge clk);
    rst_n = rn;
    req0_valid = v0; req0_data = d0; req0_last = l0;
    req1_valid = v1; req1_data = d1; req1_last = l1;
    fifo_wr_vld = wv;
    #1;
    rdy = g & {2{wv}};
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".rdy0"},  32'(req0_ready), 32'(rdy[0]));
    chk({tag, ".rdy1"},  32'(req1_ready), 32'(rdy[1]));
    chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(en));
    chk({tag, ".wdata"}, 32'(fifo_wr_data), 32'(wd));
    chk({tag, ".done"},  32'(pkt_done), 32'(done));
    chk({tag, ".err"},   32'(err_len), 32'(err));
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_data = 0; req0_last = 0;
    req1_valid = 0; req1_data = 0; req1_last = 0;
    fifo_wr_vld = 1;

    // reset: valid requests must not leak through
    cyc("rst0", 0, 1, 8'h55, 1, 1, 8'h66, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("rst1", 0, 1, 8'h55, 1, 1, 8'h66, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("rel",  1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("idle1",1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("idle2",1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0);

    // 4-beat packet from req0, last on beat 4 (also the MAX_PKT_LEN beat: no error)
    cyc("p1.bub",1, 1, 8'h11, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("p1.b1", 1, 1, 8'h11, 0, 0, 8'h00, 0, 1, 2'b01, 1, 8'h11, 0, 0);
    cyc("p1.b2", 1, 1, 8'h12, 0, 0, 8'h00, 0, 1, 2'b01, 1, 8'h12, 0, 0);
    cyc("p1.b3", 1, 1, 8'h13, 0, 0, 8'h00, 0, 1, 2'b01, 1, 8'h13, 0, 0);
    cyc("p1.b4", 1, 1, 8'h14, 1, 0, 8'h00, 0, 1, 2'b01, 1, 8'h14, 1, 0);
    cyc("p1.end",1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0);

    // both valid from reset: req0, req1, req0; first grant on third edge after release
    cyc("rr.rst",0, 1, 8'hA1, 0, 1, 8'hB1, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("rr.rel",1, 1, 8'hA1, 0, 1, 8'hB1, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("rr.s1", 1, 1, 8'hA1, 0, 1, 8'hB1, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("rr.s2", 1, 1, 8'hA1, 0, 1, 8'hB1, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("rr.a1", 1, 1, 8'hA1, 0, 1, 8'hB1, 0, 1, 2'b01, 1, 8'hA1, 0, 0);
    cyc("rr.a2", 1, 1, 8'hA2, 1, 1, 8'hB1, 0, 1, 2'b01, 1, 8'hA2, 1, 0);
    cyc("rr.bb", 1, 1, 8'hA3, 0, 1, 8'hB1, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("rr.b1", 1, 1, 8'hA3, 0, 1, 8'hB1, 0, 1, 2'b10, 1, 8'hB1, 0, 0);
    cyc("rr.b2", 1, 1, 8'hA3, 0, 1, 8'hB2, 1, 1, 2'b10, 1, 8'hB2, 1, 0);
    cyc("rr.ab", 1, 1, 8'hA3, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("rr.a3", 1, 1, 8'hA3, 0, 0, 8'h00, 0, 1, 2'b01, 1, 8'hA3, 0, 0);
    cyc("rr.a4", 1, 1, 8'hA4, 1, 0, 8'h00, 0, 1, 2'b01, 1, 8'hA4, 1, 0);

    // FIFO back-pressure for 3 cycles mid-packet; grant held, C3 written once
    cyc("st.bub",1, 0, 8'h00, 0, 1, 8'hC1, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("st.c1", 1, 0, 8'h00, 0, 1, 8'hC1, 0, 1, 2'b10, 1, 8'hC1, 0, 0);
    cyc("st.c2", 1, 0, 8'h00, 0, 1, 8'hC2, 0, 1, 2'b10, 1, 8'hC2, 0, 0);
    cyc("st.w1", 1, 0, 8'h00, 0, 1, 8'hC3, 0, 0, 2'b10, 0, 8'h00, 0, 0);
    cyc("st.w2", 1, 0, 8'h00, 0, 1, 8'hC3, 0, 0, 2'b10, 0, 8'h00, 0, 0);
    cyc("st.w3", 1, 0, 8'h00, 0, 1, 8'hC3, 0, 0, 2'b10, 0, 8'h00, 0, 0);
    cyc("st.c3", 1, 0, 8'h00, 0, 1, 8'hC3, 0, 1, 2'b10, 1, 8'hC3, 0, 0);
    cyc("st.c4", 1, 0, 8'h00, 0, 1, 8'hC4, 1, 1, 2'b10, 1, 8'hC4, 1, 0);
    // valid dropping mid-packet keeps the grant (req0 waiting must not steal it)
    cyc("vd.bub",1, 0, 8'h00, 0, 1, 8'hE1, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("vd.e1", 1, 0, 8'h00, 0, 1, 8'hE1, 0, 1, 2'b10, 1, 8'hE1, 0, 0);
    cyc("vd.gap",1, 1, 8'h99, 0, 0, 8'h00, 0, 1, 2'b10, 0, 8'h00, 0, 0);
    cyc("vd.e2", 1, 1, 8'h99, 0, 1, 8'hE2, 1, 1, 2'b10, 1, 8'hE2, 1, 0);
    cyc("vd.end",1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0);

    // truncation at MAX_PKT_LEN=4, then D5/D6 re-arbitrated as a new packet
    cyc("tr.bub",1, 0, 8'h00, 0, 1, 8'hD1, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("tr.d1", 1, 0, 8'h00, 0, 1, 8'hD1, 0, 1, 2'b10, 1, 8'hD1, 0, 0);
    cyc("tr.d2", 1, 0, 8'h00, 0, 1, 8'hD2, 0, 1, 2'b10, 1, 8'hD2, 0, 0);
    cyc("tr.d3", 1, 0, 8'h00, 0, 1, 8'hD3, 0, 1, 2'b10, 1, 8'hD3, 0, 0);
    cyc("tr.d4", 1, 0, 8'h00, 0, 1, 8'hD4, 0, 1, 2'b10, 1, 8'hD4, 1, 1);
    cyc("tr.rb", 1, 0, 8'h00, 0, 1, 8'hD5, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("tr.d5", 1, 0, 8'h00, 0, 1, 8'hD5, 0, 1, 2'b10, 1, 8'hD5, 0, 0);
    cyc("tr.d6", 1, 0, 8'h00, 0, 1, 8'hD6, 1, 1, 2'b10, 1, 8'hD6, 1, 0);

    // reset on beat 2 clears outputs at once; afterwards lone req1 wins
    cyc("mr.bub",1, 1, 8'h21, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("mr.b1", 1, 1, 8'h21, 0, 0, 8'h00, 0, 1, 2'b01, 1, 8'h21, 0, 0);
    cyc("mr.b2", 0, 1, 8'h22, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("mr.rel",1, 0, 8'h00, 0, 1, 8'h31, 1, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("mr.s1", 1, 0, 8'h00, 0, 1, 8'h31, 1, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("mr.s2", 1, 0, 8'h00, 0, 1, 8'h31, 1, 1, 2'b00, 0, 8'h00, 0, 0);
    cyc("mr.g1", 1, 0, 8'h00, 0, 1, 8'h31, 1, 1, 2'b10, 1, 8'h31, 1, 0);
    cyc("mr.end",1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0);

    @(negedge clk);
    chk("tot.writes", 32'(n_wr), 32'd24);
    chk("tot.done",   32'(n_done), 32'd9);
    chk("tot.err",    32'(n_err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
